// File: rtl/tx_req_arbiter.sv
// Two-requester arbiter in front of the single PCIe TX request/completion engine.
// Latency: valid sampled in IDLE -> tx_req_o next cycle; done pulse one cycle after tx_done_i or timeout.
// Backpressure: requests are held (level) until the TX engine finishes or the watchdog forces release.
module tx_req_arbiter #(
  parameter int DESC_W      = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prio_mode_i,
  input  logic              req0_valid_i,
  input  logic [DESC_W-1:0] req0_desc_i,
  output logic              req0_done_o,
  input  logic              req1_valid_i,
  input  logic [DESC_W-1:0] req1_desc_i,
  output logic              req1_done_o,
  output logic              tx_req_o,
  output logic [DESC_W-1:0] tx_desc_o,
  output logic              tx_src_o,
  input  logic              tx_done_i,
  output logic              timeout_o,
  output logic [7:0]        err_cnt_o
);

  localparam int WD_W = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [DESC_W-1:0] desc_q, desc_d;
  logic              src_q, src_d;
  logic              last_q, last_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [7:0]        err_q, err_d;
  logic              tmo_q, tmo_d;
  logic              gnt;

  // State and datapath registers; last grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      desc_q  <= '0;
      src_q   <= 1'b0;
      last_q  <= 1'b1;
      wd_q    <= '0;
      err_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      src_q   <= src_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // Arbitration, watchdog and next-state selection.
  always_comb begin
    state_d = state_q;
    desc_d  = desc_q;
    src_d   = src_q;
    last_d  = last_q;
    wd_d    = wd_q;
    err_d   = err_q;
    tmo_d   = 1'b0;
    gnt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0_valid_i && req1_valid_i) begin
          gnt = prio_mode_i ? 1'b0 : ~last_q;
        end else begin
          gnt = req1_valid_i;
        end
        if (req0_valid_i || req1_valid_i) begin
          desc_d  = gnt ? req1_desc_i : req0_desc_i;
          src_d   = gnt;
          last_d  = gnt;
          wd_d    = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // A done arriving on the terminal count wins over the timeout.
        if (tx_done_i) begin
          state_d = DONE;
        end else if (wd_q == WD_LAST) begin
          tmo_d   = 1'b1;
          err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
          state_d = DONE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign tx_req_o    = (state_q == BUSY);
  assign req0_done_o = (state_q == DONE) && !src_q;
  assign req1_done_o = (state_q == DONE) && src_q;
  assign tx_desc_o   = desc_q;
  assign tx_src_o    = src_q;
  assign timeout_o   = tmo_q;
  assign err_cnt_o   = err_q;

endmodule
